tick_period_monitor: RTL
========================

TICK_PERIOD_MONITOR -- requirements
Module: tick_period_monitor

Interface
REQ-001 Block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
  EXP_PERIOD  4   expected clk cycles between consecutive ticks
  LOCK_COUNT  3   consecutive matching periods required for lock
  TIMEOUT     16  cycles without a tick before loss is declared
  CW          8   interval counter and period width; 2^CW-1 >= TIMEOUT
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk           input   1   rising-edge clock
  reset         input   1   synchronous active-low reset
  tick_in       input   1   tick from upstream FSM counter; each high cycle is one tick
  period        output  CW  last measured tick-to-tick interval in cycles
  period_valid  output  1   one-cycle pulse; period updated
  locked        output  1   high while in LOCKED state
  err_pulse     output  1   one-cycle pulse on mismatched period
  timeout_flag  output  1   one-cycle pulse on tick loss
  err_count     output  8   saturating mismatch count

Function
REQ-004 All outputs SHALL be registered; no combinational path from tick_in to any output.
REQ-005 FSM SHALL have three states: IDLE (no reference tick), ACQ (measuring, not locked), LOCKED.
REQ-006 Gap counter g SHALL be 1 on the cycle after a tick, then increment each tick-free cycle, saturating at 2^CW-1.
REQ-007 On a tick in ACQ or LOCKED, period SHALL load g and period_valid SHALL pulse on the next cycle (latency 1).
REQ-008 IDLE + tick -> ACQ; match counter = 0, g = 1; no period_valid (no previous tick).
REQ-009 ACQ + tick with g == EXP_PERIOD -> match counter +1; on reaching LOCK_COUNT -> LOCKED.
REQ-010 ACQ + tick with g != EXP_PERIOD -> stay ACQ; match counter = 0; err_pulse; err_count +1.
REQ-011 LOCKED + matching tick -> stay LOCKED.
REQ-012 LOCKED + mismatching tick -> ACQ; match counter = 0; err_pulse; err_count +1.
REQ-013 ACQ or LOCKED with no tick this cycle and g == TIMEOUT -> IDLE; timeout_flag pulses for one cycle.
REQ-014 Tick and timeout condition in the same cycle -> tick processed, timeout ignored.
REQ-015 locked SHALL equal (state == LOCKED), registered; it rises the cycle after the transition into LOCKED.
REQ-016 err_count SHALL saturate at 255 and never wrap.
REQ-017 tick_in high on consecutive cycles -> each cycle is a tick with period 1.
REQ-018 IDLE SHALL ignore timeout; g SHALL still count, saturating.

Reset
REQ-019 With reset low at a rising edge: state = IDLE, g = 0, match counter = 0, period = 0, period_valid = 0, locked = 0, err_pulse = 0, timeout_flag = 0, err_count = 0.
REQ-020 Reset mid-operation SHALL abandon any measurement; the first tick after reset release is treated as the IDLE reference tick.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
  a) Reset, then tick every 4 cycles -> period = 4 with period_valid from the 2nd tick; locked = 1 the cycle after the 4th tick; err_count = 0.
  b) Locked, one tick 3 cycles after the previous -> period = 3, one err_pulse, locked = 0, err_count = 1; relocks after 3 further period-4 ticks.
  c) Locked, ticks stop -> timeout_flag pulses once when g reaches 16; locked = 0; state IDLE; next tick gives no period_valid.
  d) Reset low while LOCKED -> all outputs 0 at the next edge; after release, the 1st tick gives no period_valid.
  e) tick_in held high 300 cycles -> period = 1 every cycle; err_pulse each cycle after the 2nd; err_count stops at 255.
  f) Tick arrives exactly when g == TIMEOUT (EXP_PERIOD set to 16) -> no timeout_flag; period = 16 counted as a match.

Source files
------------

// File: rtl/tick_period_monitor_if.sv
// tick_period_monitor_if
//   Groups the tick input and the measurement/status outputs of
//   tick_period_monitor into one bundle.
//   Signals:
//     tick_in       tick from upstream FSM counter (one tick per high cycle)
//     period        last measured tick-to-tick interval in cycles (CW bits)
//     period_valid  one-cycle pulse when period is updated
//     locked        high while the monitor is in LOCKED
//     err_pulse     one-cycle pulse on a mismatched period
//     timeout_flag  one-cycle pulse on tick loss
//     err_count     saturating mismatch count
//   Modports:
//     master  drives tick_in, observes the status outputs
//     slave   the monitor itself
interface tick_period_monitor_if #(
    parameter int CW = 8
);
    logic          tick_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          err_pulse;
    logic          timeout_flag;
    logic [7:0]    err_count;

    modport master (
        output tick_in,
        input  period, period_valid, locked, err_pulse, timeout_flag, err_count
    );

    modport slave (
        input  tick_in,
        output period, period_valid, locked, err_pulse, timeout_flag, err_count
    );
endinterface

// File: rtl/tick_period_monitor.sv
// tick_period_monitor
//   Measures the interval between ticks from an upstream counter, declares
//   lock after LOCK_COUNT consecutive intervals equal to EXP_PERIOD, flags
//   mismatching intervals and declares tick loss after TIMEOUT tick-free
//   cycles. All outputs are registered.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-low reset
//     bus    tick_period_monitor_if.slave (tick_in in; period, period_valid,
//            locked, err_pulse, timeout_flag, err_count out)
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | no reference tick yet; timeout ignored
//   S_ACQ    | measuring intervals, counting matches
//   S_LOCKED | LOCK_COUNT consecutive matches seen
module tick_period_monitor #(
    parameter int EXP_PERIOD = 4,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 16,
    parameter int CW         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    tick_period_monitor_if.slave bus
);
    localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CW-1:0] G_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] EXP_G  = CW'(EXP_PERIOD);
    localparam logic [CW-1:0] TO_G   = CW'(TIMEOUT);
    localparam logic [MW-1:0] LOCK_M = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] g, g_n;
    logic [MW-1:0] match_cnt, match_cnt_n;
    logic [CW-1:0] period_q, period_n;
    logic          period_valid_q, period_valid_n;
    logic          locked_q, locked_n;
    logic          err_pulse_q, err_pulse_n;
    logic          timeout_q, timeout_n;
    logic [7:0]    err_count_q, err_count_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            g              <= '0;
            match_cnt      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_pulse_q    <= 1'b0;
            timeout_q      <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state          <= state_n;
            g              <= g_n;
            match_cnt      <= match_cnt_n;
            period_q       <= period_n;
            period_valid_q <= period_valid_n;
            locked_q       <= locked_n;
            err_pulse_q    <= err_pulse_n;
            timeout_q      <= timeout_n;
            err_count_q    <= err_count_n;
        end
    end

    always_comb begin
        state_n        = state;
        match_cnt_n    = match_cnt;
        period_n       = period_q;
        period_valid_n = 1'b0;
        err_pulse_n    = 1'b0;
        timeout_n      = 1'b0;
        err_count_n    = err_count_q;
        g_n            = (g == G_MAX) ? g : g + CW'(1);

        if (bus.tick_in) begin
            // g restarts at 1 so that back-to-back ticks measure period 1
            g_n = CW'(1);
            unique case (state)
                S_IDLE: begin
                    state_n     = S_ACQ;
                    match_cnt_n = '0;
                end
                S_ACQ, S_LOCKED: begin
                    period_n       = g;
                    period_valid_n = 1'b1;
                    if (g == EXP_G) begin
                        if (state == S_ACQ) begin
                            if (match_cnt + MW'(1) == LOCK_M) begin
                                state_n     = S_LOCKED;
                                match_cnt_n = '0;
                            end else begin
                                match_cnt_n = match_cnt + MW'(1);
                            end
                        end
                    end else begin
                        state_n     = S_ACQ;
                        match_cnt_n = '0;
                        err_pulse_n = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_n = err_count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_n     = S_IDLE;
                    match_cnt_n = '0;
                end
            endcase
        end else if (state != S_IDLE && g == TO_G) begin
            // a tick on the timeout cycle takes the branch above instead
            state_n     = S_IDLE;
            match_cnt_n = '0;
            timeout_n   = 1'b1;
        end

        locked_n = (state_n == S_LOCKED);
    end

    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.err_pulse    = err_pulse_q;
    assign bus.timeout_flag = timeout_q;
    assign bus.err_count    = err_count_q;
endmodule
